v2_reg_collection: RTL and testbench
====================================

Name: v2_reg_collection

Overview:
- Next-generation register array holding the FIFO/priority-queue storage for op-centric queues.
- Each cycle it can do any combination of:
  - remove at an arbitrary index, closing the gap;
  - insert at an arbitrary index, opening a gap;
  - up to p_nwr direct in-place updates.
- It tracks occupancy internally and exports per-entry valid, count, full and empty, so queue control logic no longer has to generate per-entry shift/write enables.

Parameters:
- p_depth, 32, number of entries (>=2).
- p_bitwidth, 32, data width per entry.
- p_nwr, 2, number of independent update ports (>=1).
- p_idwidth, $clog2(p_depth), entry index width.
- p_cntwidth, $clog2(p_depth+1), count width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ins_en  input  1  insert request
- ins_idx  input  p_idwidth  insert position
- ins_data  input  p_bitwidth  insert data
- ins_rdy  output  1  insert accepted this cycle
- rm_en  input  1  remove request
- rm_idx  input  p_idwidth  remove position
- rm_rdy  output  1  remove accepted this cycle
- upd_en  input  1 x p_nwr  update request per port
- upd_idx  input  p_idwidth x p_nwr  update position per port
- upd_data  input  p_bitwidth x p_nwr  update data per port
- err  output  1  registered: previous cycle had a rejected or ignored request
- data_out  output  p_bitwidth x p_depth  entry contents; entry 0 = head
- valid_out  output  1 x p_depth  entry i holds data (i < count)
- count  output  p_cntwidth  occupied entries
- full  output  1  count == p_depth
- empty  output  1  count == 0

Behaviour:
- One clk domain. All state updates on posedge clk.
- Reset (synchronous, active-high) has priority over every request:
  - all data_out = 0, count = 0, empty = 1, full = 0, err = 0, valid_out all 0;
  - requests presented during the reset cycle are dropped.
- Occupancy is always contiguous: valid_out[i] = (i < count). Invariant: data of every invalid entry is 0.
- Combinational, from registered state only:
  - rm_rdy = rm_en && (rm_idx < count);
  - ins_rdy = ins_en && (!full || rm_rdy).
- Per cycle, stages are applied in order on a combinational intermediate array; the result is registered.
  1. Remove (if rm_rdy):
     - entries j >= rm_idx take entry j+1;
     - entry (count-1) cleared to 0;
     - count' = count-1.
  2. Insert (if ins_rdy):
     - effective index e = min(ins_idx, count'); out-of-range inserts append at the tail, not an error;
     - entries j > e take entry j-1;
     - entry e = ins_data;
     - count'' = count'+1.
     - ins_idx is interpreted against the post-remove array.
  3. Updates:
     - each port k with upd_en[k] and upd_idx[k] < count'' overwrites entry upd_idx[k] with upd_data[k];
     - indices are interpreted against the post-insert array;
     - on index collision the highest-numbered port wins;
     - an update may overwrite the entry just inserted in the same cycle.
- Latency: all effects visible on outputs the cycle after the request. No multi-cycle operations and no internal FSM beyond the count register.
- Full + insert + accepted remove in the same cycle: both accepted; count unchanged. This is the replace path.
- Empty + remove: rejected; rm_rdy = 0. Empty + remove + insert: only the insert applies.
- err = 1 for one cycle following any of:
  - rm_en with rm_idx >= count;
  - ins_en rejected because full;
  - any upd_en[k] with an out-of-range index.
- Rejected or ignored requests never modify state.
- No wrap-around: indices are absolute positions, head is fixed at entry 0. Removing at index 0 is dequeue; inserting at count is enqueue.
- Width rules:
  - count never exceeds p_depth or goes below 0;
  - index comparisons are done at p_cntwidth width, so p_idwidth overflow at non-power-of-2 depths is impossible.

Test Plan:
- Reset then enqueue 10,20,30 (ins_idx = count) over 3 cycles -> data_out[0..2] = 10,20,30; count = 3; valid_out = 0b111; empty = 0; err = 0.
- From [10,20,30]: insert 15 at idx 1 -> [10,15,20,30], count 4. Then remove idx 0 -> [15,20,30,0], count 3, entry 3 = 0.
- Fill to p_depth:
  - insert with no remove -> ins_rdy = 0, err = 1 next cycle, state unchanged;
  - then insert 99 at idx 0 plus remove idx p_depth-1 in the same cycle -> 99 at head, others shifted up, last original entry gone, count = p_depth, full stays 1.
- From [15,20,30]:
  - same-cycle remove idx 1, insert 7 at idx 5, upd port0 idx 0 = 1, port1 idx 0 = 2 -> [2,30,7], count 3 (insert clamped; port1 wins);
  - separately, upd idx 3 with count 3 -> ignored, err = 1.
- Empty queue, remove idx 0 -> rm_rdy = 0, err = 1, count stays 0. Same with a concurrent insert 5 -> [5], count 1.
- Mid-operation reset: assert rst together with ins_en/rm_en on a half-full queue -> next cycle count = 0, all data_out = 0, err = 0.

Source files
------------

// File: rtl/v2_reg_collection_if.sv
// ---------------------------------------------------------------------------
// v2_reg_collection_if
//   Request/response bundle for the v2_reg_collection register array.
//   master : queue control logic (drives insert/remove/update requests)
//   slave  : the register array (returns handshakes, contents and occupancy)
//   Signals:
//     ins_en/ins_idx/ins_data -> ins_rdy   insert request and acceptance
//     rm_en/rm_idx            -> rm_rdy    remove request and acceptance
//     upd_en/upd_idx/upd_data              p_nwr in-place update ports
//     err, data_out, valid_out, count, full, empty   array state
// ---------------------------------------------------------------------------
interface v2_reg_collection_if #(
    parameter int p_depth    = 32,
    parameter int p_bitwidth = 32,
    parameter int p_nwr      = 2,
    parameter int p_idwidth  = $clog2(p_depth),
    parameter int p_cntwidth = $clog2(p_depth + 1)
);
    logic                                  ins_en;
    logic [p_idwidth-1:0]                  ins_idx;
    logic [p_bitwidth-1:0]                 ins_data;
    logic                                  ins_rdy;
    logic                                  rm_en;
    logic [p_idwidth-1:0]                  rm_idx;
    logic                                  rm_rdy;
    logic [p_nwr-1:0]                      upd_en;
    logic [p_nwr-1:0][p_idwidth-1:0]       upd_idx;
    logic [p_nwr-1:0][p_bitwidth-1:0]      upd_data;
    logic                                  err;
    logic [p_depth-1:0][p_bitwidth-1:0]    data_out;
    logic [p_depth-1:0]                    valid_out;
    logic [p_cntwidth-1:0]                 count;
    logic                                  full;
    logic                                  empty;

    modport master (
        output ins_en, ins_idx, ins_data, rm_en, rm_idx, upd_en, upd_idx, upd_data,
        input  ins_rdy, rm_rdy, err, data_out, valid_out, count, full, empty
    );

    modport slave (
        input  ins_en, ins_idx, ins_data, rm_en, rm_idx, upd_en, upd_idx, upd_data,
        output ins_rdy, rm_rdy, err, data_out, valid_out, count, full, empty
    );
endinterface

// File: rtl/v2_reg_collection.sv
// ---------------------------------------------------------------------------
// v2_reg_collection
//   Contiguous register array backing FIFO / priority-queue storage. Each
//   cycle applies, in order: remove-at-index (close gap), insert-at-index
//   (open gap), then up to p_nwr in-place updates. Head is fixed at entry 0.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset, overrides every request
//     bus  - v2_reg_collection_if.slave (requests, handshakes, state)
// ---------------------------------------------------------------------------
module v2_reg_collection #(
    parameter int p_depth    = 32,
    parameter int p_bitwidth = 32,
    parameter int p_nwr      = 2,
    parameter int p_idwidth  = $clog2(p_depth),
    parameter int p_cntwidth = $clog2(p_depth + 1)
) (
    input  logic                clk,
    input  logic                rst,
    v2_reg_collection_if.slave  bus
);
    typedef logic [p_depth-1:0][p_bitwidth-1:0] arr_t;

    arr_t                  data_q, data_d;
    logic [p_cntwidth-1:0] count_q, count_d;
    logic                  err_q, err_d;

    logic                  full_w, rm_ok, ins_ok;
    logic [p_cntwidth-1:0] rm_pos, ins_pos, ins_eff, cnt1;
    arr_t                  arr1, arr2;

    // All index compares happen at count width so a non-power-of-2 depth
    // can never alias an index onto a valid entry.
    assign rm_pos  = p_cntwidth'(bus.rm_idx);
    assign ins_pos = p_cntwidth'(bus.ins_idx);
    assign full_w  = (count_q == p_cntwidth'(p_depth));
    assign rm_ok   = bus.rm_en && (rm_pos < count_q);
    // A same-cycle remove frees a slot, so a full array can still insert.
    assign ins_ok  = bus.ins_en && (!full_w || rm_ok);

    assign cnt1    = count_q - p_cntwidth'(rm_ok);
    // Out-of-range inserts append at the tail of the post-remove array.
    assign ins_eff = (ins_pos < cnt1) ? ins_pos : cnt1;
    assign count_d = cnt1 + p_cntwidth'(ins_ok);

    // Stage 1: remove. Shifting down pulls in the (always zero) invalid
    // entry above the tail, so the vacated slot clears itself.
    always_comb begin
        arr1 = data_q;
        if (rm_ok) begin
            for (int j = 0; j < p_depth - 1; j++) begin
                if (j >= int'(rm_pos)) arr1[j] = data_q[j+1];
            end
            arr1[p_depth-1] = '0;
        end
    end

    // Stage 2: insert. When an insert is accepted the top entry of arr1 is
    // invalid, so nothing live falls off the end.
    always_comb begin
        arr2 = arr1;
        if (ins_ok) begin
            for (int j = 1; j < p_depth; j++) begin
                if (j > int'(ins_eff)) arr2[j] = arr1[j-1];
            end
            for (int j = 0; j < p_depth; j++) begin
                if (j == int'(ins_eff)) arr2[j] = bus.ins_data;
            end
        end
    end

    // Stage 3: updates against the post-insert array; ascending port order
    // lets the highest-numbered port win a collision.
    always_comb begin
        data_d = arr2;
        err_d  = (bus.rm_en && !rm_ok) || (bus.ins_en && !ins_ok);
        for (int k = 0; k < p_nwr; k++) begin
            if (bus.upd_en[k]) begin
                if (p_cntwidth'(bus.upd_idx[k]) < count_d) begin
                    for (int j = 0; j < p_depth; j++) begin
                        if (j == int'(bus.upd_idx[k])) data_d[j] = bus.upd_data[k];
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < p_depth; i++) begin
            bus.valid_out[i] = (p_cntwidth'(i) < count_q);
        end
    end

    assign bus.ins_rdy  = ins_ok;
    assign bus.rm_rdy   = rm_ok;
    assign bus.err      = err_q;
    assign bus.data_out = data_q;
    assign bus.count    = count_q;
    assign bus.full     = full_w;
    assign bus.empty    = (count_q == '0);
endmodule

// File: tb/tb_v2_reg_collection.sv
// ---------------------------------------------------------------------------
// tb_v2_reg_collection
//   Directed bench for v2_reg_collection (depth 4, two update ports). The
//   driver issues one request set per cycle and queues the hand-computed
//   result; an independent monitor pops each entry and compares handshakes
//   (sampled just before the edge) and the registered state after the edge.
// ---------------------------------------------------------------------------
module tb_v2_reg_collection;
    localparam int D  = 4;
    localparam int W  = 32;
    localparam int N  = 2;
    localparam int IW = 2;
    localparam int CW = 3;

    typedef logic [D*W-1:0] wide_t;

    typedef struct {
        string               nm;
        logic [D-1:0][W-1:0] d;
        int                  c;
        bit                  er;
        bit                  crdy;
        bit                  ir;
        bit                  rr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    v2_reg_collection_if #(.p_depth(D), .p_bitwidth(W), .p_nwr(N),
                           .p_idwidth(IW), .p_cntwidth(CW)) bus ();

    v2_reg_collection #(.p_depth(D), .p_bitwidth(W), .p_nwr(N),
                        .p_idwidth(IW), .p_cntwidth(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string nm, input string what, input wide_t act, input wide_t ex);
        tests++;
        if (act !== ex) begin
            fails++;
            $display("FAIL %s %s: got %0h expected %0h", nm, what, act, ex);
        end
    endtask

    // Drive one cycle of requests and queue the expected outcome.
    task automatic op(input string nm, input bit r,
                      input bit ie, input int ii, input int idat,
                      input bit re, input int ri,
                      input bit [N-1:0] ue, input int ui0, input int ud0, input int ui1, input int ud1,
                      input int e0, input int e1, input int e2, input int e3, input int ec,
                      input bit eerr, input bit crdy, input bit eir, input bit err_rdy);
        exp_t x;
        @(negedge clk);
        rst             = r;
        bus.ins_en      = ie;
        bus.ins_idx     = IW'(ii);
        bus.ins_data    = W'(idat);
        bus.rm_en       = re;
        bus.rm_idx      = IW'(ri);
        bus.upd_en      = ue;
        bus.upd_idx[0]  = IW'(ui0);
        bus.upd_data[0] = W'(ud0);
        bus.upd_idx[1]  = IW'(ui1);
        bus.upd_data[1] = W'(ud1);
        x.nm   = nm;
        x.d[0] = W'(e0);
        x.d[1] = W'(e1);
        x.d[2] = W'(e2);
        x.d[3] = W'(e3);
        x.c    = ec;
        x.er   = eerr;
        x.crdy = crdy;
        x.ir   = eir;
        x.rr   = err_rdy;
        sb.push_back(x);
    endtask

    // Monitor: handshakes just before the edge, state just after it.
    initial begin
        exp_t x;
        logic ir, rr;
        logic [D-1:0] vmask;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() != 0) begin
                x  = sb.pop_front();
                ir = bus.ins_rdy;
                rr = bus.rm_rdy;
                @(posedge clk);
                #1;
                if (x.crdy) begin
                    check(x.nm, "ins_rdy", wide_t'(ir), wide_t'(x.ir));
                    check(x.nm, "rm_rdy",  wide_t'(rr), wide_t'(x.rr));
                end
                vmask = '0;
                for (int i = 0; i < D; i++) if (i < x.c) vmask[i] = 1'b1;
                check(x.nm, "count",     wide_t'(bus.count),     wide_t'(x.c));
                check(x.nm, "err",       wide_t'(bus.err),       wide_t'(x.er));
                check(x.nm, "data_out",  wide_t'(bus.data_out),  wide_t'(x.d));
                check(x.nm, "valid_out", wide_t'(bus.valid_out), wide_t'(vmask));
                check(x.nm, "full",      wide_t'(bus.full),      wide_t'(x.c == D));
                check(x.nm, "empty",     wide_t'(bus.empty),     wide_t'(x.c == 0));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.ins_en = 1'b0; bus.ins_idx = '0; bus.ins_data = '0;
        bus.rm_en  = 1'b0; bus.rm_idx  = '0;
        bus.upd_en = '0;   bus.upd_idx = '0; bus.upd_data = '0;

        //  name            rst ie ii dat  re ri  ue     ui0 ud0 ui1 ud1  e0 e1 e2 e3 cnt err crdy ir rr
        op("reset",         1,  1, 0, 55,  1, 0,  2'b00, 0, 0,  0, 0,   0, 0, 0, 0, 0,  0,  0,   0, 0);
        op("enq10",         0,  1, 0, 10,  0, 0,  2'b00, 0, 0,  0, 0,  10, 0, 0, 0, 1,  0,  1,   1, 0);
        op("enq20",         0,  1, 1, 20,  0, 0,  2'b00, 0, 0,  0, 0,  10,20, 0, 0, 2,  0,  1,   1, 0);
        op("enq30",         0,  1, 2, 30,  0, 0,  2'b00, 0, 0,  0, 0,  10,20,30, 0, 3,  0,  1,   1, 0);
        op("ins15_mid",     0,  1, 1, 15,  0, 0,  2'b00, 0, 0,  0, 0,  10,15,20,30, 4,  0,  1,   1, 0);
        op("deq_head",      0,  0, 0, 0,   1, 0,  2'b00, 0, 0,  0, 0,  15,20,30, 0, 3,  0,  1,   0, 1);
        op("fill",          0,  1, 3, 40,  0, 0,  2'b00, 0, 0,  0, 0,  15,20,30,40, 4,  0,  1,   1, 0);
        op("ins_when_full", 0,  1, 0, 50,  0, 0,  2'b00, 0, 0,  0, 0,  15,20,30,40, 4,  1,  1,   0, 0);
        op("replace",       0,  1, 0, 99,  1, 3,  2'b00, 0, 0,  0, 0,  99,15,20,30, 4,  0,  1,   1, 1);
        op("deq_head2",     0,  0, 0, 0,   1, 0,  2'b00, 0, 0,  0, 0,  15,20,30, 0, 3,  0,  1,   0, 1);
        op("combo_clamp",   0,  1, 3, 7,   1, 1,  2'b11, 0, 1,  0, 2,   2,30, 7, 0, 3,  0,  1,   1, 1);
        op("upd_oob",       0,  0, 0, 0,   0, 0,  2'b01, 3, 77, 0, 0,   2,30, 7, 0, 3,  1,  1,   0, 0);
        op("rm_upd",        0,  0, 0, 0,   1, 0,  2'b10, 0, 0,  1, 8,  30, 8, 0, 0, 2,  0,  1,   0, 1);
        op("drain_a",       0,  0, 0, 0,   1, 0,  2'b00, 0, 0,  0, 0,   8, 0, 0, 0, 1,  0,  1,   0, 1);
        op("drain_b",       0,  0, 0, 0,   1, 0,  2'b00, 0, 0,  0, 0,   0, 0, 0, 0, 0,  0,  1,   0, 1);
        op("rm_empty",      0,  0, 0, 0,   1, 0,  2'b00, 0, 0,  0, 0,   0, 0, 0, 0, 0,  1,  1,   0, 0);
        op("rm_ins_empty",  0,  1, 2, 5,   1, 0,  2'b00, 0, 0,  0, 0,   5, 0, 0, 0, 1,  1,  1,   1, 0);
        op("enq6",          0,  1, 1, 6,   0, 0,  2'b00, 0, 0,  0, 0,   5, 6, 0, 0, 2,  0,  1,   1, 0);
        op("rst_mid",       1,  1, 0, 9,   1, 0,  2'b00, 0, 0,  0, 0,   0, 0, 0, 0, 0,  0,  1,   1, 1);
        op("idle",          0,  0, 0, 0,   0, 0,  2'b00, 0, 0,  0, 0,   0, 0, 0, 0, 0,  0,  1,   0, 0);

        @(negedge clk);
        rst = 1'b0;
        bus.ins_en = 1'b0; bus.rm_en = 1'b0; bus.upd_en = '0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
